// File: rtl/rrf_entry_allocate_pkg.sv
// Shared rename-register-file sizing and the types derived from it.
// Rename, ROB and RRF logic all import this so tag widths stay consistent.
package rrf_entry_allocate_pkg;

    localparam int unsigned RRF_NUM = 64;
    localparam int unsigned RRF_SEL = $clog2(RRF_NUM);

    typedef logic [RRF_SEL-1:0] rrf_tag_t;   // entry tag / allocation pointer
    typedef logic [RRF_SEL:0]   rrf_cnt_t;   // free count, 0..RRF_NUM inclusive
    typedef logic [RRF_SEL+1:0] rrf_sum_t;   // headroom for free + commit

    localparam rrf_cnt_t FREE_FULL = rrf_cnt_t'(RRF_NUM);
    localparam rrf_sum_t SUM_CAP   = rrf_sum_t'(RRF_NUM);
    localparam rrf_tag_t PTR_LAST  = rrf_tag_t'(RRF_NUM - 1);

endpackage

// File: rtl/rrf_entry_allocate.sv
// RRF free-list manager: hands out one tag per dispatch from a circular
// pointer and returns entries to the pool as instructions commit.
module rrf_entry_allocate
    import rrf_entry_allocate_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     com_inst_num_i,
    input  logic           stall_dp_i,
    output logic           rrf_allocatable_o,
    output logic [RRF_SEL:0]   freenum_o,
    output logic [RRF_SEL-1:0] dst_rename_rrftag_o,
    output logic [RRF_SEL-1:0] rrfptr_o,
    output logic           nextrrfcyc_o
);

    rrf_cnt_t freenum_q, freenum_d;
    rrf_tag_t rrfptr_q,  rrfptr_d;
    rrf_sum_t avail;
    rrf_sum_t remain;
    logic     alloc;

    // NOTE: every signal written here gets a value before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alloc  = ~stall_dp_i;
        avail  = rrf_sum_t'(freenum_q) + rrf_sum_t'(com_inst_num_i);
        remain = '0;
        if (avail >= rrf_sum_t'(alloc)) begin
            remain = avail - rrf_sum_t'(alloc);
        end

        // Spurious commits must never push the count past capacity.
        freenum_d = (remain > SUM_CAP) ? FREE_FULL : rrf_cnt_t'(remain);

        rrfptr_d = rrfptr_q;
        if (alloc) begin
            rrfptr_d = rrfptr_q + rrf_tag_t'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freenum_q <= FREE_FULL;
            rrfptr_q  <= '0;
        end else begin
            freenum_q <= freenum_d;
            rrfptr_q  <= rrfptr_d;
        end
    end

    // Same-cycle commits already count as free for this cycle's dispatch.
    assign rrf_allocatable_o   = (avail != '0);
    assign freenum_o           = freenum_q;
    assign rrfptr_o            = rrfptr_q;
    assign dst_rename_rrftag_o = rrfptr_q;
    assign nextrrfcyc_o        = alloc & (rrfptr_q == PTR_LAST);

endmodule

// File: tb/tb_rrf_entry_allocate.sv
// Directed self-checking bench for the RRF free-list manager.
module tb_rrf_entry_allocate;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] com_inst_num_i;
    logic       stall_dp_i;
    logic       rrf_allocatable_o;
    logic [6:0] freenum_o;
    logic [5:0] dst_rename_rrftag_o;
    logic [5:0] rrfptr_o;
    logic       nextrrfcyc_o;

    int n_cmp = 0;
    int n_bad = 0;

    rrf_entry_allocate dut (
        .clk                 (clk),
        .reset               (reset),
        .com_inst_num_i      (com_inst_num_i),
        .stall_dp_i          (stall_dp_i),
        .rrf_allocatable_o   (rrf_allocatable_o),
        .freenum_o           (freenum_o),
        .dst_rename_rrftag_o (dst_rename_rrftag_o),
        .rrfptr_o            (rrfptr_o),
        .nextrrfcyc_o        (nextrrfcyc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic [1:0] com);
        stall_dp_i     = stall;
        com_inst_num_i = com;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 2'd0);

        // Reset held for two cycles.
        tick();
        tick();
        check("rst_freenum", freenum_o, 64);
        check("rst_ptr", rrfptr_o, 0);
        check("rst_tag", dst_rename_rrftag_o, 0);
        check("rst_allocatable", rrf_allocatable_o, 1);
        check("rst_nextcyc", nextrrfcyc_o, 0);
        reset = 1'b0;

        // Steady allocation: pointer 0..10, free count 64..54.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 2'd0);
            check("steady_ptr", rrfptr_o, i);
            check("steady_tag", dst_rename_rrftag_o, i);
            check("steady_free", freenum_o, 64 - i);
            tick();
        end
        check("steady_ptr_end", rrfptr_o, 10);
        check("steady_free_end", freenum_o, 54);

        // Commit two while allocating one, then commit one while allocating one.
        drive(1'b0, 2'd2);
        tick();
        check("cmt2_alloc_free", freenum_o, 55);
        check("cmt2_alloc_ptr", rrfptr_o, 11);
        drive(1'b0, 2'd1);
        tick();
        check("cmt1_alloc_free", freenum_o, 55);
        check("cmt1_alloc_ptr", rrfptr_o, 12);

        // Restart from reset and exhaust all 64 entries.
        reset = 1'b1;
        drive(1'b1, 2'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 2'd0);
            check("exh_allocatable", rrf_allocatable_o, 1);
            check("exh_nextcyc", nextrrfcyc_o, (i == 63) ? 1 : 0);
            tick();
        end
        check("exh_free", freenum_o, 0);
        check("exh_ptr_wrapped", rrfptr_o, 0);
        drive(1'b1, 2'd0);
        check("empty_allocatable", rrf_allocatable_o, 0);

        // Stall tied to ~allocatable: nothing moves while empty.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0);
            stall_dp_i = ~rrf_allocatable_o;
            #1;
            check("empty_stall", stall_dp_i, 1);
            tick();
            check("empty_hold_ptr", rrfptr_o, 0);
            check("empty_hold_free", freenum_o, 0);
        end

        // Protocol violation: allocate while empty, count clamps at zero.
        drive(1'b0, 2'd0);
        tick();
        check("viol_free_clamp", freenum_o, 0);
        check("viol_ptr", rrfptr_o, 1);

        // One commit while empty makes allocation possible in the same cycle.
        drive(1'b0, 2'd1);
        stall_dp_i = ~rrf_allocatable_o;
        #1;
        check("empty_cmt_allocatable", rrf_allocatable_o, 1);
        tick();
        check("empty_cmt_free", freenum_o, 0);
        check("empty_cmt_ptr", rrfptr_o, 2);

        // Walk pointer to 63 with balanced commit/alloc.
        for (int i = 0; i < 61; i++) begin
            drive(1'b0, 2'd1);
            tick();
        end
        check("pre_wrap_ptr", rrfptr_o, 63);
        check("pre_wrap_free", freenum_o, 0);

        // Stalled at 63: no wrap flag, pointer holds.
        drive(1'b1, 2'd0);
        check("wrap_stall_nextcyc", nextrrfcyc_o, 0);
        tick();
        check("wrap_stall_ptr", rrfptr_o, 63);

        // Allocating at 63: wrap flag this cycle, pointer to 0 next.
        drive(1'b0, 2'd1);
        check("wrap_nextcyc", nextrrfcyc_o, 1);
        check("wrap_tag", dst_rename_rrftag_o, 63);
        tick();
        check("wrap_ptr", rrfptr_o, 0);
        check("wrap_free", freenum_o, 0);

        // Saturation at full capacity.
        reset = 1'b1;
        drive(1'b1, 2'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 2'd2);
        tick();
        check("sat_stall_free", freenum_o, 64);
        check("sat_stall_ptr", rrfptr_o, 0);
        drive(1'b0, 2'd2);
        tick();
        check("sat_alloc_free", freenum_o, 64);
        check("sat_alloc_ptr", rrfptr_o, 1);

        // Asynchronous reset between edges takes effect immediately.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0);
            tick();
        end
        check("pre_async_ptr", rrfptr_o, 5);
        check("pre_async_free", freenum_o, 60);
        #2;
        reset = 1'b1;
        #1;
        check("async_free", freenum_o, 64);
        check("async_ptr", rrfptr_o, 0);
        check("async_tag", dst_rename_rrftag_o, 0);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'd0);
        tick();
        check("post_async_ptr", rrfptr_o, 1);
        check("post_async_free", freenum_o, 63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
